seven_segment_monitor: RTL and testbench

//   Receive end of the seven-segment seconds interface: samples a 7-bit segment bus from an

---
 rtl/seven_segment_monitor_if.sv | 23 ++
 rtl/seven_segment_monitor.sv | 162 ++++++++++++++++
 tb/tb_seven_segment_monitor.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_monitor_if.sv
// Seven-segment seconds bus as seen by the receive-side monitor.
// master: the side that drives the segment bus and observes the monitor results.
// slave:  the monitor itself.
interface seven_segment_monitor_if;
  logic [6:0] seg_in;
  logic [3:0] digit;
  logic       digit_valid;
  logic       step;
  logic       seq_err;
  logic       bad_pattern;
  logic [7:0] err_count;
  logic       stalled;

  modport master (
    output seg_in,
    input  digit, digit_valid, step, seq_err, bad_pattern, err_count, stalled
  );

  modport slave (
    input  seg_in,
    output digit, digit_valid, step, seq_err, bad_pattern, err_count, stalled
  );
endinterface

// File: rtl/seven_segment_monitor.sv
// seven_segment_monitor: receive end of a seven-segment seconds display bus.
// Synchronises the asynchronous segment bus, filters glitches, decodes the
// pattern back to a digit and checks that accepted digits advance by +1 mod 10.
module seven_segment_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 32'h0020_0000
) (
  input logic                    clk,
  input logic                    reset,
  seven_segment_monitor_if.slave bus
);

  localparam logic [7:0]  STABLE_MAX  = STABLE_CYCLES[7:0];
  localparam logic [23:0] TIMEOUT_MAX = TIMEOUT[23:0];

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  // Maps a segment pattern to {is_digit, digit}; blank and garbage give is_digit=0.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h3F:   res = {1'b1, 4'd0};
      7'h06:   res = {1'b1, 4'd1};
      7'h5B:   res = {1'b1, 4'd2};
      7'h4F:   res = {1'b1, 4'd3};
      7'h66:   res = {1'b1, 4'd4};
      7'h6D:   res = {1'b1, 4'd5};
      7'h7D:   res = {1'b1, 4'd6};
      7'h07:   res = {1'b1, 4'd7};
      7'h7F:   res = {1'b1, 4'd8};
      7'h6F:   res = {1'b1, 4'd9};
      default: res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  // Input path and filter state.
  logic [6:0]  sync1_q, sync2_q, prev_q, last_q;
  logic        have_last_q;
  logic [7:0]  stable_cnt_q, stable_cnt_d;
  logic        accept_s;
  logic [4:0]  dec_s;
  logic        is_digit_s, is_blank_s;
  logic [3:0]  dec_digit_s, next_digit_s;

  // Checker state and registered outputs.
  state_t      state_q;
  logic [3:0]  digit_q;
  logic        digit_valid_q, step_q, seq_err_q, bad_q, stalled_q;
  logic [7:0]  err_cnt_q, err_inc_s;
  logic [23:0] timer_q, timer_d;

  assign dec_s        = seg_decode(sync2_q);
  assign is_digit_s   = dec_s[4];
  assign dec_digit_s  = dec_s[3:0];
  assign is_blank_s   = (sync2_q == 7'h00);
  assign next_digit_s = (digit_q == 4'd9) ? 4'd0 : (digit_q + 4'd1);
  assign err_inc_s    = (err_cnt_q == 8'hFF) ? 8'hFF : (err_cnt_q + 8'd1);

  // Glitch filter: count consecutive unchanged cycles; accept a new pattern once it has held long enough.
  always_comb begin
    stable_cnt_d = 8'd0;
    if (sync2_q != prev_q) begin
      stable_cnt_d = 8'd0;
    end else if (stable_cnt_q >= STABLE_MAX) begin
      stable_cnt_d = STABLE_MAX;
    end else begin
      stable_cnt_d = stable_cnt_q + 8'd1;
    end
    accept_s = (stable_cnt_d == STABLE_MAX) && (!have_last_q || (sync2_q != last_q));
  end

  // Stall timer: runs only while locked with no new acceptance, saturating at the timeout.
  always_comb begin
    timer_d = 24'd0;
    if (accept_s || (state_q == UNLOCKED)) begin
      timer_d = 24'd0;
    end else if (timer_q == TIMEOUT_MAX) begin
      timer_d = TIMEOUT_MAX;
    end else begin
      timer_d = timer_q + 24'd1;
    end
  end

  // Two-flop synchroniser plus the filter history and last accepted pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 7'h00;
      sync2_q      <= 7'h00;
      prev_q       <= 7'h00;
      stable_cnt_q <= 8'd0;
      last_q       <= 7'h00;
      have_last_q  <= 1'b0;
    end else begin
      sync1_q      <= bus.seg_in;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      stable_cnt_q <= stable_cnt_d;
      if (accept_s) begin
        last_q      <= sync2_q;
        have_last_q <= 1'b1;
      end
    end
  end

  // Lock FSM: classifies each accepted pattern and produces pulses, error count and stall flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= UNLOCKED;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      step_q        <= 1'b0;
      seq_err_q     <= 1'b0;
      bad_q         <= 1'b0;
      err_cnt_q     <= 8'd0;
      timer_q       <= 24'd0;
      stalled_q     <= 1'b0;
    end else begin
      step_q    <= 1'b0;
      seq_err_q <= 1'b0;
      bad_q     <= 1'b0;
      timer_q   <= timer_d;
      stalled_q <= (timer_d == TIMEOUT_MAX);
      if (accept_s) begin
        if (is_digit_s) begin
          // A mismatching digit becomes the new reference without dropping lock.
          if (state_q == LOCKED) begin
            if (dec_digit_s == next_digit_s) begin
              step_q <= 1'b1;
            end else begin
              seq_err_q <= 1'b1;
              err_cnt_q <= err_inc_s;
            end
          end
          state_q       <= LOCKED;
          digit_q       <= dec_digit_s;
          digit_valid_q <= 1'b1;
        end else if (is_blank_s) begin
          state_q       <= UNLOCKED;
          digit_valid_q <= 1'b0;
        end else begin
          state_q       <= UNLOCKED;
          digit_valid_q <= 1'b0;
          bad_q         <= 1'b1;
          err_cnt_q     <= err_inc_s;
        end
      end
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.step        = step_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.bad_pattern = bad_q;
  assign bus.err_count   = err_cnt_q;
  assign bus.stalled     = stalled_q;

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Self-checking bench for seven_segment_monitor: table of held patterns,
// hand-written stall/saturation/reset sequences and random stimulus, every
// cycle compared against a window-based reference model.
module tb_seven_segment_monitor;
  localparam int STABLE = 4;
  localparam int TMO    = 64;

  logic clk = 1'b0;
  logic reset;

  seven_segment_monitor_if bus();

  seven_segment_monitor #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model state
  logic [6:0] hist [$];
  logic [6:0] m_last;
  bit         m_have, m_locked, m_valid, m_step, m_seq, m_badp, m_stall;
  int         m_digit, m_err, m_idle;

  // Pulse accumulators for table rows / sequences
  int acc_step, acc_seq, acc_bad;

  typedef struct {
    logic [6:0] seg;
    int hold;
    int e_digit;
    int e_valid;
    int e_step;
    int e_seq;
    int e_bad;
    int e_err;
  } vec_t;
  vec_t vt [$];

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pat_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_have = 1'b0; m_locked = 1'b0; m_valid = 1'b0; m_step = 1'b0;
    m_seq = 1'b0; m_badp = 1'b0; m_stall = 1'b0; m_last = 7'h00;
    m_digit = 0; m_err = 0; m_idle = 0;
    hist.delete();
    for (int i = 0; i < STABLE + 3; i++) hist.push_back(7'h00);
  endtask

  // One clock edge of the model: a pattern counts once it has been sampled
  // STABLE+1 times in a row (ending two samples back, for the synchroniser)
  // and differs from the last pattern counted.
  task automatic model_step(input logic [6:0] v);
    logic [6:0] c;
    bit same;
    int d;
    hist.push_back(v);
    void'(hist.pop_front());
    c = hist[0];
    same = 1'b1;
    for (int i = 1; i <= STABLE; i++) if (hist[i] != c) same = 1'b0;
    m_step = 1'b0; m_seq = 1'b0; m_badp = 1'b0;
    if (same && (!m_have || c != m_last)) begin
      m_have = 1'b1;
      m_last = c;
      d = lookup(c);
      m_idle = 0;
      if (d >= 0) begin
        if (m_locked) begin
          if (d == (m_digit + 1) % 10) m_step = 1'b1;
          else begin
            m_seq = 1'b1;
            if (m_err < 255) m_err++;
          end
        end
        m_locked = 1'b1; m_digit = d; m_valid = 1'b1;
      end else if (c == 7'h00) begin
        m_locked = 1'b0; m_valid = 1'b0;
      end else begin
        m_locked = 1'b0; m_valid = 1'b0; m_badp = 1'b1;
        if (m_err < 255) m_err++;
      end
    end else if (m_locked) begin
      if (m_idle < TMO) m_idle++;
    end
    m_stall = m_locked && (m_idle == TMO);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive one pattern for one clock and compare all outputs with the model.
  task automatic tick(input logic [6:0] v);
    logic [16:0] got, exp;
    @(negedge clk);
    bus.seg_in = v;
    @(posedge clk);
    model_step(v);
    #1;
    got = {bus.digit, bus.digit_valid, bus.step, bus.seq_err, bus.bad_pattern,
           bus.err_count, bus.stalled};
    exp = {4'(m_digit), m_valid, m_step, m_seq, m_badp, 8'(m_err), m_stall};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL model_cycle seg=%02h: got %05h expected %05h", v, got, exp);
    end
    acc_step += int'(bus.step);
    acc_seq  += int'(bus.seq_err);
    acc_bad  += int'(bus.bad_pattern);
  endtask

  task automatic add_vec(input logic [6:0] seg, input int hold, input int dg,
                         input int vl, input int st, input int sq, input int bd,
                         input int er);
    vec_t r;
    r.seg = seg; r.hold = hold; r.e_digit = dg; r.e_valid = vl;
    r.e_step = st; r.e_seq = sq; r.e_bad = bd; r.e_err = er;
    vt.push_back(r);
  endtask

  task automatic clr_acc();
    acc_step = 0; acc_seq = 0; acc_bad = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int found;
    logic [6:0] pat;
    int hold;
    int sel;

    // seg, hold, digit, valid, steps, seq_errs, bad, err_count
    add_vec(7'h3F, 20, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add_vec(pat_tab[i], 20, i, 1, 1, 0, 0, 0);
    add_vec(7'h3F, 20, 0, 1, 1, 0, 0, 0);
    add_vec(7'h06, 20, 1, 1, 1, 0, 0, 0);
    add_vec(7'h7F,  3, 1, 1, 0, 0, 0, 0);
    add_vec(7'h06, 20, 1, 1, 0, 0, 0, 0);
    add_vec(7'h00, 20, 1, 0, 0, 0, 0, 0);
    add_vec(7'h3F, 20, 0, 1, 0, 0, 0, 0);
    add_vec(7'h06, 20, 1, 1, 1, 0, 0, 0);
    add_vec(7'h66, 20, 4, 1, 0, 1, 0, 1);
    add_vec(7'h6D, 20, 5, 1, 1, 0, 0, 1);
    add_vec(7'h49, 20, 5, 0, 0, 0, 1, 2);
    add_vec(7'h5B, 20, 2, 1, 0, 0, 0, 2);

    reset = 1'b1;
    bus.seg_in = 7'h00;
    model_reset();
    clr_acc();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset digit",       int'(bus.digit), 0);
    chk("reset digit_valid", int'(bus.digit_valid), 0);
    chk("reset step",        int'(bus.step), 0);
    chk("reset seq_err",     int'(bus.seq_err), 0);
    chk("reset bad_pattern", int'(bus.bad_pattern), 0);
    chk("reset err_count",   int'(bus.err_count), 0);
    chk("reset stalled",     int'(bus.stalled), 0);

    repeat (10) tick(7'h00);

    // Table-driven held patterns
    foreach (vt[i]) begin
      clr_acc();
      for (int k = 0; k < vt[i].hold; k++) tick(vt[i].seg);
      chk($sformatf("vec%0d digit", i),     int'(bus.digit),       vt[i].e_digit);
      chk($sformatf("vec%0d valid", i),     int'(bus.digit_valid), vt[i].e_valid);
      chk($sformatf("vec%0d steps", i),     acc_step,              vt[i].e_step);
      chk($sformatf("vec%0d seq_errs", i),  acc_seq,               vt[i].e_seq);
      chk($sformatf("vec%0d bad", i),       acc_bad,               vt[i].e_bad);
      chk($sformatf("vec%0d err_count", i), int'(bus.err_count),   vt[i].e_err);
    end

    // Lock on 3, latency and stall timing
    repeat (10) tick(7'h00);
    clr_acc();
    lat = 0; found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      tick(7'h4F);
      if (bus.digit_valid) begin found = 1; lat = k; end
    end
    chk("lock3 latency", lat, STABLE + 3);
    chk("lock3 digit", int'(bus.digit), 3);
    chk("lock3 no step", acc_step + acc_seq, 0);
    repeat (TMO - 1) tick(7'h4F);
    chk("stall before timeout", int'(bus.stalled), 0);
    tick(7'h4F);
    chk("stall at timeout", int'(bus.stalled), 1);
    repeat (100 - TMO - lat) tick(7'h4F);
    chk("stall held", int'(bus.stalled), 1);
    clr_acc();
    lat = 0; found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      tick(7'h66);
      if (bus.step) begin found = 1; lat = k; end
    end
    chk("step4 latency", lat, STABLE + 3);
    chk("step4 digit", int'(bus.digit), 4);
    chk("step4 stall cleared", int'(bus.stalled), 0);

    // Error counter saturation
    clr_acc();
    for (int i = 0; i < 300; i++) begin
      pat = (i % 2 == 1) ? 7'h49 : 7'h12;
      repeat (6) tick(pat);
    end
    repeat (8) tick(7'h00);
    chk("sat bad pulses", acc_bad, 300);
    chk("sat err_count", int'(bus.err_count), 255);

    // Asynchronous reset mid-sequence
    repeat (20) tick(7'h3F);
    repeat (20) tick(7'h06);
    repeat (3) tick(7'h5B);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset digit",     int'(bus.digit), 0);
    chk("areset valid",     int'(bus.digit_valid), 0);
    chk("areset err_count", int'(bus.err_count), 0);
    chk("areset pulses",    int'(bus.step) + int'(bus.seq_err) + int'(bus.bad_pattern), 0);
    chk("areset stalled",   int'(bus.stalled), 0);
    model_reset();
    bus.seg_in = 7'h00;
    @(negedge clk);
    reset = 1'b0;
    clr_acc();
    repeat (20) tick(7'h4F);
    chk("relock digit", int'(bus.digit), 3);
    chk("relock valid", int'(bus.digit_valid), 1);
    chk("relock no pulse", acc_step + acc_seq + acc_bad, 0);
    repeat (20) tick(7'h66);
    chk("relock step", acc_step, 1);

    // Random stimulus against the model
    for (int r = 0; r < 250; r++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       pat = pat_tab[(m_digit + 1) % 10];
      else if (sel < 8)  pat = pat_tab[$urandom_range(0, 9)];
      else if (sel == 8) pat = 7'h00;
      else               pat = 7'($urandom_range(0, 127));
      hold = int'($urandom_range(1, 12));
      repeat (hold) tick(pat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
